// File: rtl/serial_addsub_if.sv
// Start/busy/done handshake and operand/result bus of the bit-serial adder/subtractor.
// The requester drives start/op/a/b; the arithmetic unit drives the result, flags and status.
interface serial_addsub_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic             op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] r;
  logic             carry_out;
  logic             overflow;
  logic             zero;
  logic             busy;
  logic             done;

  modport master (
    output start, op, a, b,
    input  r, carry_out, overflow, zero, busy, done
  );

  modport slave (
    input  start, op, a, b,
    output r, carry_out, overflow, zero, busy, done
  );
endinterface

// File: rtl/serial_addsub.sv
// serial_addsub: WIDTH-bit add/subtract computed LSB first through one full-adder cell.
// Optional macro SERIAL_ADDSUB_SAT_EN: saturate r on signed overflow instead of wrapping.
module serial_addsub #(
  parameter int WIDTH = 4
) (
  input logic            clk,
  input logic            reset,
  serial_addsub_if.slave bus
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nx;
  logic             load, step, last;
  logic             busy, done;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sa, sb;
  logic [WIDTH-2:0] part;
  logic             c;
  logic             s, c_nx, ovf;
  logic [WIDTH-1:0] sum_full, res;
  logic [WIDTH-1:0] r_q;
  logic             carry_q, ovf_q, zero_q;

`ifdef SERIAL_ADDSUB_SAT_EN
  // Overflow direction follows the sign of a: positive overflow clamps to max, negative to min.
  function automatic logic [WIDTH-1:0] saturate(input logic [WIDTH-1:0] v,
                                                input logic             ovf_i,
                                                input logic             sign_a);
    logic [WIDTH-1:0] lim;
    lim = {sign_a, {(WIDTH-1){~sign_a}}};
    return ovf_i ? lim : v;
  endfunction
`endif

  // Full-adder cell on the current LSBs
  always_comb begin
    s    = sa[0] ^ sb[0] ^ c;
    c_nx = (sa[0] & sb[0]) | (sa[0] & c) | (sb[0] & c);
    ovf  = c ^ c_nx;
    last = (cnt == CW'(WIDTH - 1));
  end

  // On the final bit the fresh sum bit tops off the partial result
  assign sum_full = {s, part};

`ifdef SERIAL_ADDSUB_SAT_EN
  assign res = saturate(sum_full, ovf, sa[0]);
`else
  assign res = sum_full;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    step     = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          load     = 1'b1;
          state_nx = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        step = 1'b1;
        if (last) state_nx = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (bus.start) begin
          load     = 1'b1;
          state_nx = RUN;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Operand shift registers, carry, counter and result/flag registers
  always_ff @(posedge clk) begin
    if (reset) begin
      sa      <= '0;
      sb      <= '0;
      part    <= '0;
      c       <= 1'b0;
      cnt     <= '0;
      r_q     <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b1;
    end else if (load) begin
      sa   <= bus.a;
      sb   <= bus.op ? ~bus.b : bus.b;
      c    <= bus.op;
      part <= '0;
      cnt  <= '0;
    end else if (step) begin
      sa   <= {1'b0, sa[WIDTH-1:1]};
      sb   <= {1'b0, sb[WIDTH-1:1]};
      c    <= c_nx;
      part <= sum_full[WIDTH-1:1];
      cnt  <= cnt + 1'b1;
      if (last) begin
        r_q     <= res;
        carry_q <= c_nx;
        ovf_q   <= ovf;
        zero_q  <= (res == '0);
      end
    end
  end

  assign bus.r         = r_q;
  assign bus.carry_out = carry_q;
  assign bus.overflow  = ovf_q;
  assign bus.zero      = zero_q;
  assign bus.busy      = busy;
  assign bus.done      = done;
endmodule

// File: tb/tb_serial_addsub.sv
// Scoreboard bench for serial_addsub at WIDTH=4 and WIDTH=8 against an integer reference model.
module tb_serial_addsub;
  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_addsub_if #(.WIDTH(4)) b4 ();
  serial_addsub_if #(.WIDTH(8)) b8 ();

  serial_addsub #(.WIDTH(4)) dut4 (.clk(clk), .reset(reset), .bus(b4));
  serial_addsub #(.WIDTH(8)) dut8 (.clk(clk), .reset(reset), .bus(b8));

  typedef struct {
    int r;
    bit c;
    bit v;
    bit z;
    int cyc;
  } exp_t;

  exp_t q4[$];
  exp_t q8[$];
  int   d8[$];
  int   checks = 0;
  int   passes = 0;

  task automatic check(string name, longint act, longint exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Reference: plain integer arithmetic on the operand values
  function automatic exp_t model(int w, bit op, int a, int b, int at);
    exp_t   e;
    longint m    = longint'(1) << w;
    longint half = m / 2;
    longint sa   = (a >= half) ? a - m : a;
    longint sb   = (b >= half) ? b - m : b;
    longint tru  = op ? sa - sb : sa + sb;
    longint u    = op ? longint'(a) + m - longint'(b) : longint'(a) + longint'(b);
    e.c = (u >= m);
    e.v = (tru >= half) || (tru < -half);
    e.r = int'(u % m);
`ifdef SERIAL_ADDSUB_SAT_EN
    if (e.v) e.r = (tru > 0) ? int'(half - 1) : int'(half);
`endif
    e.z = (e.r == 0);
    e.cyc = at;
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (b4.done === 1'b1) begin
      if (q4.size() == 0) check("w4 unexpected done", 1, 0);
      else begin
        e = q4.pop_front();
        check("w4 r", b4.r, e.r);
        check("w4 carry_out", b4.carry_out, e.c);
        check("w4 overflow", b4.overflow, e.v);
        check("w4 zero", b4.zero, e.z);
        check("w4 done cycle", cyc, e.cyc);
        check("w4 busy at done", b4.busy, 0);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (b8.done === 1'b1) begin
      d8.push_back(cyc);
      if (q8.size() == 0) check("w8 unexpected done", 1, 0);
      else begin
        e = q8.pop_front();
        check("w8 r", b8.r, e.r);
        check("w8 carry_out", b8.carry_out, e.c);
        check("w8 overflow", b8.overflow, e.v);
        check("w8 zero", b8.zero, e.z);
        check("w8 done cycle", cyc, e.cyc);
        check("w8 busy at done", b8.busy, 0);
      end
    end
  end

  task automatic issue4(bit op, int a, int b);
    int guard = 0;
    while (b4.busy !== 1'b0 && guard < 100) begin
      b4.a  = 4'($urandom);
      b4.b  = 4'($urandom);
      b4.op = 1'($urandom);
      @(posedge clk); #1;
      guard++;
    end
    if (b4.busy !== 1'b0) check("w4 idle timeout", 1, 0);
    b4.start = 1'b1;
    b4.op    = op;
    b4.a     = 4'(a);
    b4.b     = 4'(b);
    q4.push_back(model(4, op, a, b, cyc + 1 + 4));
    @(posedge clk); #1;
    b4.start = 1'b0;
    check("w4 busy after start", b4.busy, 1);
  endtask

  task automatic issue8(bit op, int a, int b);
    int guard = 0;
    while (b8.busy !== 1'b0 && guard < 100) begin
      b8.a  = 8'($urandom);
      b8.b  = 8'($urandom);
      b8.op = 1'($urandom);
      @(posedge clk); #1;
      guard++;
    end
    if (b8.busy !== 1'b0) check("w8 idle timeout", 1, 0);
    b8.start = 1'b1;
    b8.op    = op;
    b8.a     = 8'(a);
    b8.b     = 8'(b);
    q8.push_back(model(8, op, a, b, cyc + 1 + 8));
    @(posedge clk); #1;
    b8.start = 1'b0;
    check("w8 busy after start", b8.busy, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int guard;
    reset    = 1'b1;
    b4.start = 1'b0; b4.op = 1'b0; b4.a = '0; b4.b = '0;
    b8.start = 1'b0; b8.op = 1'b0; b8.a = '0; b8.b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("w4 reset r", b4.r, 0);
    check("w4 reset carry", b4.carry_out, 0);
    check("w4 reset ovf", b4.overflow, 0);
    check("w4 reset zero", b4.zero, 1);
    check("w4 reset busy", b4.busy, 0);
    check("w4 reset done", b4.done, 0);
    check("w8 reset r", b8.r, 0);
    check("w8 reset zero", b8.zero, 1);
    check("w8 reset busy", b8.busy, 0);
    check("w8 reset done", b8.done, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    issue4(0, 10, 15);
    issue4(1, 1, 4);
    issue4(1, 4, 4);
    issue4(0, 7, 1);
    issue4(1, 8, 1);

    // Second start in the middle of RUN must be ignored
    issue4(0, 3, 5);
    @(posedge clk); #1;
    check("w4 busy mid-run", b4.busy, 1);
    b4.start = 1'b1; b4.op = 1'b1; b4.a = 4'd15; b4.b = 4'd2;
    @(posedge clk); #1;
    b4.start = 1'b0;

    // Reset in the middle of RUN aborts without a done pulse
    issue4(1, 9, 2);
    @(posedge clk); #1;
    void'(q4.pop_back());
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("w4 abort busy", b4.busy, 0);
    check("w4 abort done", b4.done, 0);
    check("w4 abort r", b4.r, 0);
    check("w4 abort zero", b4.zero, 1);
    check("w4 abort carry", b4.carry_out, 0);
    check("w4 abort ovf", b4.overflow, 0);
    repeat (8) @(posedge clk);
    #1;
    issue4(0, 2, 3);

    for (int i = 0; i < 30; i++) begin
      issue4(1'($urandom), int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
      repeat ($urandom_range(0, 6)) @(posedge clk);
      #1;
    end

    // Back-to-back 8-bit pair issued in the DONE cycle
    guard = 0;
    while (b4.busy !== 1'b0 && guard < 100) begin @(posedge clk); #1; guard++; end
    issue8(0, 200, 100);
    issue8(1, 100, 200);
    for (int i = 0; i < 20; i++)
      issue8(1'($urandom), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));

    guard = 0;
    while ((q4.size() != 0 || q8.size() != 0) && guard < 300) begin
      @(posedge clk); #1;
      guard++;
    end
    check("w4 outstanding results", q4.size(), 0);
    check("w8 outstanding results", q8.size(), 0);
    check("w8 done pulses seen", (d8.size() >= 2) ? 1 : 0, 1);
    if (d8.size() >= 2) check("w8 back-to-back spacing", d8[1] - d8[0], 9);
    check("w8 done pulse count", d8.size(), 22);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/serial_addsub.md
# serial_addsub

Bit-serial, parametrised adder/subtractor: the sequential successor of the 4-bit combinational add/subtract unit. A start pulse latches two WIDTH-bit operands and an operation select. The block then computes one result bit per clock, LSB first, through a single full-adder cell, and reports the result with carry, signed-overflow and zero flags. It serves the datapath labs as an area-minimal arithmetic unit with a start/busy/done handshake.

## Interface
- WIDTH, 4, operand/result width in bits; legal range 2..32.
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request pulse; sampled only when busy=0.
- op  input  1  0 = add (a+b), 1 = subtract (a-b).
- a  input  WIDTH  first operand, sampled with start.
- b  input  WIDTH  second operand, sampled with start.
- r  output  WIDTH  result register; holds value until next completion.
- carry_out  output  1  final carry (for subtract: 1 = no borrow, a>=b unsigned).
- overflow  output  1  two's-complement overflow of the operation.
- zero  output  1  r == 0.
- busy  output  1  high while bits are being computed.
- done  output  1  one-cycle completion pulse.

## Operation
- States: IDLE, RUN, DONE.
- IDLE/DONE + start=1:
  - Latch a into shift register SA and b (inverted if op=1) into SB.
  - Set carry register c = op.
  - Clear bit counter. Go to RUN, busy=1.
- RUN, each edge:
  - s = SA[0]^SB[0]^c; c <= majority(SA[0],SB[0],c).
  - Shift SA/SB right by one; shift s into partial-result register from MSB side.
  - Counter increments.
  - On the edge that processes bit WIDTH-1:
    - Load r from the completed partial result.
    - carry_out <= new c; overflow <= (carry into MSB) ^ (carry out of MSB); zero <= (result==0).
    - Go to DONE, done=1, busy=0.
- DONE lasts exactly one cycle, then returns to IDLE unless start is sampled, in which case the block goes straight to RUN (back-to-back).
- start while busy=1: ignored; a, b and op changes during RUN have no effect.
- Arithmetic is modulo 2^WIDTH unless saturation is compiled in (see Configuration).
- r, carry_out, overflow and zero change only at completion.

## Timing
- Reset (synchronous, checked at the edge): state=IDLE, r=0, carry_out=0, overflow=0, zero=1, busy=0, done=0, internal registers cleared.
- Reset has priority over start and aborts a RUN in progress; no done pulse is produced and outputs take reset values.
- Latency:
  - Start sampled at edge E0.
  - busy high from after E0 through edge E(WIDTH).
  - r and flags valid, with done=1, in the cycle after edge E(WIDTH).
- Throughput: one operation per WIDTH+1 cycles sustained; back-to-back start during the DONE cycle gives WIDTH+1 spacing.
- done is high for exactly one cycle per accepted start.

## Configuration
- SERIAL_ADDSUB_SAT_EN defined: on signed overflow, r saturates.
  - r = 0 followed by WIDTH-1 ones (max positive) if sign of a is 0.
  - r = 1 followed by WIDTH-1 zeros (min negative) if sign of a is 1.
  - overflow still reports 1; carry_out is unaffected; zero is computed on the saturated r.
- Not defined: r wraps modulo 2^WIDTH; no saturation logic is built.

## Test plan
- WIDTH=4, add a=10, b=15 -> done 4 cycles after start edge, r=9, carry_out=1, overflow=0 (-6 + -1 = -7), zero=0.
- Subtract a=1, b=4 -> r=13, carry_out=0 (borrow), overflow=0; subtract a=4, b=4 -> r=0, zero=1, carry_out=1.
- Add a=7, b=1 -> overflow=1:
  - without SERIAL_ADDSUB_SAT_EN, r=8;
  - with it, r=7.
  - Subtract a=8, b=1 -> overflow=1, r=7 wrap / r=8 saturated.
- Start pulsed again at cycle 2 of RUN with different operands -> ignored; result matches the first operands; exactly one done pulse.
- Reset asserted at cycle 2 of RUN -> next cycle busy=0, r=0, zero=1, no done pulse; a fresh start afterwards completes normally.
- WIDTH=8, back-to-back start in the DONE cycle: 200+100 then 100-200 -> r=44 with carry_out=1, then r=156 with carry_out=0; done pulses exactly 9 cycles apart.
